pmu_pwr_seq: RTL and testbench

PMU_PWR_SEQ -- requirements
Module: pmu_pwr_seq

---
 rtl/pmu_pkg.sv | 38 +++
 rtl/pmu_seq_cnt.sv | 37 +++
 rtl/pmu_pwr_seq.sv | 176 +++++++++++++++++
 tb/tb_pmu_pwr_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_pkg.sv
// Shared types for the PMU power sequencer: state encodings,
// registered output bundle and the state-to-output decode.
package pmu_pkg;

  localparam int PMU_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_ISO_ON    = 3'd2,
    ST_RST_ON    = 3'd3,
    ST_SLEEP     = 3'd4,
    ST_CLK_ON    = 3'd5,
    ST_RST_OFF   = 3'd6,
    ST_ISO_OFF   = 3'd7
  } pmu_state_e;

  typedef struct packed {
    logic iso;
    logic rst;
    logic clk_en;
    logic ack;
  } pmu_outs_t;

  // Level outputs are a pure function of the state being entered,
  // so registering this decode of the next state yields outputs that
  // switch on the same edge as the state.
  function automatic pmu_outs_t pmu_state_outs(pmu_state_e s);
    pmu_outs_t o;
    o.iso    = (s inside {ST_ISO_ON, ST_RST_ON, ST_SLEEP,
                          ST_CLK_ON, ST_RST_OFF});
    o.rst    = (s inside {ST_RST_ON, ST_SLEEP, ST_CLK_ON});
    o.clk_en = (s != ST_SLEEP);
    o.ack    = (s == ST_SLEEP);
    return o;
  endfunction

endpackage

// File: rtl/pmu_seq_cnt.sv
// Loadable down counter with zero flag, shared by the timed states.
// Ports: clk_i, rst_ni, ld_i/ld_val_i (load), dec_i, zero_o.
module pmu_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pmu_pwr_seq.sv
// Sleep/wake power sequencer: isolate -> reset -> gate clock on entry,
// exact reverse on wake. Inputs: clk_16m, rstn_16m, sleep_req,
// wakeup_evt, bus_idle, cfg_rst_hold, cfg_settle. Outputs: sleep_rst,
// iso_en, clk_gate_en, sleep_ack, sleep_abort, wake_done, pmu_state.
module pmu_pwr_seq
  import pmu_pkg::*;
#(
  parameter int D     = 1,
  parameter int CNT_W = PMU_CNT_W
) (
  input  logic             clk_16m,
  input  logic             rstn_16m,
  input  logic             sleep_req,
  input  logic             wakeup_evt,
  input  logic             bus_idle,
  input  logic [CNT_W-1:0] cfg_rst_hold,
  input  logic [CNT_W-1:0] cfg_settle,
  output logic             sleep_rst,
  output logic             iso_en,
  output logic             clk_gate_en,
  output logic             sleep_ack,
  output logic             sleep_abort,
  output logic             wake_done,
  output logic [2:0]       pmu_state
);

  // D is a simulation-only assignment delay with no functional role.
  if (D < 0) begin : g_bad_d
    $error("pmu_pwr_seq: D must be non-negative");
  end
  if (CNT_W < 1) begin : g_bad_w
    $error("pmu_pwr_seq: CNT_W must be at least 1");
  end

  pmu_state_e       state_q;
  pmu_state_e       state_d;
  pmu_outs_t        outs_q;
  logic             abort_q;
  logic             abort_d;
  logic             done_q;
  logic             done_d;
  logic             pend_q;
  logic             pend_d;

  logic             cnt_ld;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  pmu_seq_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i    (clk_16m),
    .rst_ni   (rstn_16m),
    .ld_i     (cnt_ld),
    .ld_val_i (cnt_val),
    .dec_i    (cnt_dec),
    .zero_o   (cnt_zero)
  );

  // The counter is loaded on the edge that enters a timed state, so
  // the first cycle in that state already sees the cfg value; exit
  // happens on the edge where it reads zero (value+1 cycles total).
  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    done_d  = 1'b0;
    pend_d  = pend_q;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    cnt_val = '0;
    unique case (state_q)
      ST_RUN: begin
        if (sleep_req) begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        // Abort beats bus_idle: entry is still reversible here.
        if (wakeup_evt || !sleep_req) begin
          state_d = ST_RUN;
          abort_d = 1'b1;
        end else if (bus_idle) begin
          state_d = ST_ISO_ON;
        end
      end
      ST_ISO_ON: begin
        state_d = ST_RST_ON;
        cnt_ld  = 1'b1;
        cnt_val = cfg_rst_hold;
        if (wakeup_evt) begin
          pend_d = 1'b1;
        end
      end
      ST_RST_ON: begin
        if (wakeup_evt) begin
          pend_d = 1'b1;
        end
        if (cnt_zero) begin
          state_d = ST_SLEEP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_SLEEP: begin
        // A wake seen during entry makes SLEEP a single cycle.
        if (wakeup_evt || pend_q) begin
          state_d = ST_CLK_ON;
          pend_d  = 1'b0;
          cnt_ld  = 1'b1;
          cnt_val = cfg_settle;
        end
      end
      ST_CLK_ON: begin
        if (cnt_zero) begin
          state_d = ST_RST_OFF;
          cnt_ld  = 1'b1;
          cnt_val = cfg_rst_hold;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RST_OFF: begin
        if (cnt_zero) begin
          state_d = ST_ISO_OFF;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_ISO_OFF: begin
        state_d = ST_RUN;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_16m or negedge rstn_16m) begin
    if (!rstn_16m) begin
      state_q <= ST_RUN;
      outs_q  <= pmu_state_outs(ST_RUN);
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      outs_q  <= pmu_state_outs(state_d);
      abort_q <= abort_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign sleep_rst   = outs_q.rst;
  assign iso_en      = outs_q.iso;
  assign clk_gate_en = outs_q.clk_en;
  assign sleep_ack   = outs_q.ack;
  assign sleep_abort = abort_q;
  assign wake_done   = done_q;
  assign pmu_state   = state_q;

  // Ordering invariants: reset only under isolation, clock only
  // stopped while reset is held.
  a_rst_iso: assert property (
    @(posedge clk_16m) disable iff (!rstn_16m)
    sleep_rst |-> iso_en);
  a_clk_rst: assert property (
    @(posedge clk_16m) disable iff (!rstn_16m)
    !clk_gate_en |-> sleep_rst);
  a_ack_clk: assert property (
    @(posedge clk_16m) disable iff (!rstn_16m)
    sleep_ack == !clk_gate_en);

endmodule

// File: tb/tb_pmu_pwr_seq.sv
// Scoreboard bench for pmu_pwr_seq: driver queues expected sleep
// transactions, a negedge monitor measures and compares them.
module tb_pmu_pwr_seq;

  localparam int CW = 4;

  logic          clk_16m    = 1'b0;
  logic          rstn_16m   = 1'b0;
  logic          sleep_req  = 1'b0;
  logic          wakeup_evt = 1'b0;
  logic          bus_idle   = 1'b0;
  logic [CW-1:0] cfg_rst_hold = '0;
  logic [CW-1:0] cfg_settle   = '0;
  logic          sleep_rst;
  logic          iso_en;
  logic          clk_gate_en;
  logic          sleep_ack;
  logic          sleep_abort;
  logic          wake_done;
  logic [2:0]    pmu_state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit wake;
    int iso_on;
    int rst_on;
    int slp;
    int clk_on;
    int rst_off;
    int iso_off;
  } txn_t;

  txn_t exp_q[$];

  always #5 clk_16m = ~clk_16m;

  pmu_pwr_seq #(
    .D     (1),
    .CNT_W (CW)
  ) dut (
    .clk_16m      (clk_16m),
    .rstn_16m     (rstn_16m),
    .sleep_req    (sleep_req),
    .wakeup_evt   (wakeup_evt),
    .bus_idle     (bus_idle),
    .cfg_rst_hold (cfg_rst_hold),
    .cfg_settle   (cfg_settle),
    .sleep_rst    (sleep_rst),
    .iso_en       (iso_en),
    .clk_gate_en  (clk_gate_en),
    .sleep_ack    (sleep_ack),
    .sleep_abort  (sleep_abort),
    .wake_done    (wake_done),
    .pmu_state    (pmu_state)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic txn_t mk_txn(input bit wake, input int rst,
                                  input int slp, input int clk);
    txn_t t;
    t.wake    = wake;
    t.iso_on  = wake ? 1 : 0;
    t.rst_on  = rst;
    t.slp     = slp;
    t.clk_on  = clk;
    t.rst_off = rst;
    t.iso_off = wake ? 1 : 0;
    return t;
  endfunction

  // Output levels each state must present.
  function automatic int e_iso(input int s);
    return (s >= 2 && s <= 6) ? 1 : 0;
  endfunction
  function automatic int e_rst(input int s);
    return (s >= 3 && s <= 5) ? 1 : 0;
  endfunction
  function automatic int e_clk(input int s);
    return (s != 4) ? 1 : 0;
  endfunction
  function automatic int e_ack(input int s);
    return (s == 4) ? 1 : 0;
  endfunction

  // ---------------- monitor ----------------
  int   seg_len;
  int   prev_st;
  txn_t obs;
  bit   iso_seen;
  bit   rst_seen;
  bit   prev_abort;
  bit   prev_done;

  always @(negedge clk_16m) begin
    if (!rstn_16m) begin
      seg_len    = 0;
      prev_st    = 0;
      obs        = mk_txn(0, 0, 0, 0);
      iso_seen   = 0;
      rst_seen   = 0;
      prev_abort = 0;
      prev_done  = 0;
    end else begin
      chk("map_iso", iso_en, e_iso(pmu_state));
      chk("map_rst", sleep_rst, e_rst(pmu_state));
      chk("map_clk", clk_gate_en, e_clk(pmu_state));
      chk("map_ack", sleep_ack, e_ack(pmu_state));
      if (int'(pmu_state) == prev_st) begin
        seg_len++;
      end else begin
        case (prev_st)
          2: obs.iso_on  = seg_len;
          3: obs.rst_on  = seg_len;
          4: obs.slp     = seg_len;
          5: obs.clk_on  = seg_len;
          6: obs.rst_off = seg_len;
          7: obs.iso_off = seg_len;
          default: ;
        endcase
        prev_st = int'(pmu_state);
        seg_len = 1;
      end
      iso_seen |= iso_en;
      rst_seen |= sleep_rst;
      if (sleep_abort) begin
        int   qn;
        txn_t e;
        qn = exp_q.size();
        chk("abort_width", int'(prev_abort), 0);
        chk("abort_state", pmu_state, 0);
        chk("abort_pending", int'(qn > 0), 1);
        if (qn > 0) begin
          e = exp_q.pop_front();
          chk("abort_kind", 0, int'(e.wake));
          chk("abort_iso", int'(iso_seen), 0);
          chk("abort_rst", int'(rst_seen), 0);
        end
        obs = mk_txn(0, 0, 0, 0);
        iso_seen = 0;
        rst_seen = 0;
      end
      if (wake_done) begin
        int   qn;
        txn_t e;
        qn = exp_q.size();
        chk("done_width", int'(prev_done), 0);
        chk("done_state", pmu_state, 0);
        chk("done_pending", int'(qn > 0), 1);
        if (qn > 0) begin
          e = exp_q.pop_front();
          chk("done_kind", 1, int'(e.wake));
          chk("len_iso_on", obs.iso_on, e.iso_on);
          chk("len_rst_on", obs.rst_on, e.rst_on);
          chk("len_sleep", obs.slp, e.slp);
          chk("len_clk_on", obs.clk_on, e.clk_on);
          chk("len_rst_off", obs.rst_off, e.rst_off);
          chk("len_iso_off", obs.iso_off, e.iso_off);
        end
        obs = mk_txn(0, 0, 0, 0);
        iso_seen = 0;
        rst_seen = 0;
      end
      prev_abort = sleep_abort;
      prev_done  = wake_done;
    end
  end

  // ---------------- driver ----------------
  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk_16m);
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk_16m);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, pmu_state, 0);
    chk({tag, "_rst"}, sleep_rst, 0);
    chk({tag, "_iso"}, iso_en, 0);
    chk({tag, "_clk"}, clk_gate_en, 1);
    chk({tag, "_ack"}, sleep_ack, 0);
    chk({tag, "_abort"}, sleep_abort, 0);
    chk({tag, "_done"}, wake_done, 0);
  endtask

  // Sleep request held for n cycles with the bus busy, then
  // withdrawn or overridden by a wakeup (bus_idle random at that point).
  task automatic abort_txn(input int n, input bit use_wake);
    exp_q.push_back(mk_txn(0, 0, 0, 0));
    bus_idle  = 1'b0;
    sleep_req = 1'b1;
    repeat (n) @(posedge clk_16m);
    #1;
    bus_idle = 1'($urandom);
    if (use_wake) wakeup_evt = 1'b1;
    else sleep_req = 1'b0;
    @(posedge clk_16m);
    #1;
    wakeup_evt = 1'b0;
    sleep_req  = 1'b0;
    bus_idle   = 1'b0;
    drain();
  endtask

  // Edge 0 samples sleep_req in RUN; bus busy for m cycles of
  // WAIT_IDLE; wakeup first sampled at edge k (k >= m+2), width w.
  task automatic full_cycle(input int h, input int s, input int m,
                            input int k, input int w, input bit hold);
    int slp;
    int e_run;
    slp = k - 3 - h - m;
    if (slp < 1) slp = 1;
    e_run = m + 2 * h + s + slp + 6;
    exp_q.push_back(mk_txn(1, h + 1, slp, s + 1));
    if (hold) exp_q.push_back(mk_txn(0, 0, 0, 0));
    cfg_rst_hold = CW'(h);
    cfg_settle   = CW'(s);
    bus_idle  = 1'b0;
    sleep_req = 1'b1;
    for (int c = 0; c <= e_run + 1; c++) begin
      @(posedge clk_16m);
      #1;
      if (c == m) bus_idle = 1'b1;
      if (c == m + 2) bus_idle = 1'b0;
      // cfg churn while RST_ON counts down must not matter
      if (c >= m + 2 && c <= m + 2 + h) begin
        cfg_rst_hold = CW'($urandom);
        cfg_settle   = CW'($urandom);
      end
      if (c == m + 3 + h) begin
        cfg_rst_hold = CW'(h);
        cfg_settle   = CW'(s);
      end
      if (c == k - 1) begin
        wakeup_evt = 1'b1;
        sleep_req  = hold;
      end
      if (c == k - 1 + w) wakeup_evt = 1'b0;
    end
    if (hold) begin
      repeat ($urandom_range(1, 4)) @(posedge clk_16m);
      #1;
      sleep_req = 1'b0;
    end
    wakeup_evt = 1'b0;
    drain();
    sleep_req = 1'b0;
  endtask

  task automatic reset_in_sleep(input int h);
    cfg_rst_hold = CW'(h);
    cfg_settle   = CW'(5);
    bus_idle  = 1'b1;
    sleep_req = 1'b1;
    repeat (h + 5) @(posedge clk_16m);
    #2;
    chk("pre_rst_state", pmu_state, 4);
    rstn_16m  = 1'b0;
    sleep_req = 1'b0;
    bus_idle  = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    repeat (2) @(posedge clk_16m);
    #3;
    rstn_16m = 1'b1;
    @(negedge clk_16m);
    chk("post_rst_state", pmu_state, 0);
    chk("post_rst_clk", clk_gate_en, 1);
    @(posedge clk_16m);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk_16m);
    #1;
    check_reset_vals("por");
    #2;
    rstn_16m = 1'b1;
    @(posedge clk_16m);
    #1;

    abort_txn(5, 1'b0);
    abort_txn(3, 1'b1);
    full_cycle(3, 7, 0, 20, 1, 1'b0);
    full_cycle(0, 7, 0, 3, 1, 1'b0);
    full_cycle(2, 4, 1, 3, 1, 1'b0);
    full_cycle(15, 15, 0, 5, 1, 1'b0);
    full_cycle(15, 15, 2, 40, 2, 1'b0);
    full_cycle(2, 3, 1, 10, 1, 1'b1);
    reset_in_sleep(2);
    full_cycle(1, 1, 0, 12, 1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        abort_txn($urandom_range(1, 8), 1'($urandom_range(0, 1)));
      end else begin
        int h;
        int s;
        int m;
        int k;
        h = $urandom_range(0, 15);
        s = $urandom_range(0, 15);
        m = $urandom_range(0, 4);
        k = m + 2 + $urandom_range(0, 30);
        full_cycle(h, s, m, k, $urandom_range(1, 3),
                   1'($urandom_range(0, 3) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
